// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch unit bundle: instruction memory, redirect and decode-side signals
`timescale 1ns/1ps
interface ifetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_pc, fetch_count,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_pc, fetch_count,
        output out_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-outstanding instruction fetch FSM with redirect and stale-response discard
`timescale 1ns/1ps
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_unit_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        discard, discard_n;
    logic        out_valid, out_valid_n;
    logic [31:0] out_instr, out_instr_n;
    logic [31:0] out_pc, out_pc_n;
    logic [31:0] fetch_count, fetch_count_n;
    logic [31:0] redirect_aligned;

    assign redirect_aligned = bus.redirect_pc & ~32'h3;

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = out_valid;
    assign bus.out_instr      = out_instr;
    assign bus.out_pc         = out_pc;
    assign bus.fetch_count    = fetch_count;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        discard_n     = discard;
        out_valid_n   = out_valid;
        out_instr_n   = out_instr;
        out_pc_n      = out_pc;
        fetch_count_n = fetch_count;
        case (state)
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_n   = WAIT;
                    discard_n = bus.redirect_valid;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    // A response is stale if a redirect arrived earlier or arrives now
                    if (discard || bus.redirect_valid) begin
                        discard_n = 1'b0;
                        state_n   = REQ;
                    end else begin
                        out_instr_n = bus.imem_rsp_data;
                        out_pc_n    = pc;
                        out_valid_n = 1'b1;
                        pc_n        = pc + 32'd4;
                        state_n     = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    discard_n = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_n   = 1'b0;
                    fetch_count_n = fetch_count + 32'd1;
                    state_n       = REQ;
                end else if (bus.redirect_valid) begin
                    out_valid_n = 1'b0;
                    state_n     = REQ;
                end
            end
            default: state_n = REQ;
        endcase
        if (bus.redirect_valid) begin
            pc_n = redirect_aligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= REQ;
            pc          <= {RESET_PC[31:2], 2'b00};
            discard     <= 1'b0;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            discard     <= discard_n;
            out_valid   <= out_valid_n;
            out_instr   <= out_instr_n;
            out_pc      <= out_pc_n;
            fetch_count <= fetch_count_n;
        end
    end
endmodule
